// File: rtl/opll_seq_pkg.sv
// Shared types and default YM2413 timing for the OPLL write sequencer.
package opll_seq_pkg;

  typedef enum logic [2:0] {
    IDLE,
    SETUP,
    STROBE,
    HOLD,
    WAIT
  } seq_state_t;

  typedef struct packed {
    logic       a0;
    logic [7:0] d;
  } opll_entry_t;

  // Counts are in 21.48 MHz CLK_EN ticks (6 ticks per OPLL master cycle).
  localparam int OPLL_STROBE_TICKS = 6;
  localparam int OPLL_ADDR_WAIT    = 72;
  localparam int OPLL_DATA_WAIT    = 504;

  function automatic int max3(input int a, input int b, input int c);
    int m;
    m = (a > b) ? a : b;
    return (m > c) ? m : c;
  endfunction

endpackage

// File: rtl/opll_seq_fifo.sv
// Synchronous FIFO shared by the OPLL/PSG/SCC write sequencers.
// A push is accepted at full only when a pop happens in the same cycle.
module opll_seq_fifo #(
  parameter int DEPTH = 16,
  parameter int WIDTH = 9,
  localparam int AW   = $clog2(DEPTH)
) (
  input  logic             CLK,
  input  logic             RESET_n,
  input  logic             CLR,
  input  logic             PUSH,
  input  logic             POP,
  input  logic [WIDTH-1:0] WDATA,
  output logic [WIDTH-1:0] RDATA,
  output logic             FULL,
  output logic             EMPTY,
  output logic [AW:0]      LEVEL
);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW:0]      wr_ptr;
  logic [AW:0]      rd_ptr;
  logic             do_push;
  logic             do_pop;

  assign do_pop  = POP && !EMPTY && !CLR;
  assign do_push = PUSH && (!FULL || do_pop) && !CLR;
  assign LEVEL   = wr_ptr - rd_ptr;
  assign FULL    = (LEVEL == (AW+1)'(DEPTH));
  assign EMPTY   = (wr_ptr == rd_ptr);
  assign RDATA   = mem[rd_ptr[AW-1:0]];

  // Pointer update; the extra MSB distinguishes full from empty.
  always_ff @(posedge CLK or negedge RESET_n) begin
    if (!RESET_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else if (CLR) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + (AW+1)'(1);
      if (do_pop)  rd_ptr <= rd_ptr + (AW+1)'(1);
    end
  end

  // Storage write; contents need no reset since pointers gate visibility.
  always_ff @(posedge CLK) begin
    if (do_push) mem[wr_ptr[AW-1:0]] <= WDATA;
  end

endmodule

// File: rtl/opll_write_sequencer.sv
// Paces buffered CPU writes into the OPLL core at YM2413 timing.
// Optional macro OPLL_SEQ_DROPCNT_EN adds DROP_CNT, a saturating count of
// writes discarded while the FIFO was full.
//
// state  | meaning
// IDLE   | waiting for a FIFO entry; pops and asserts CS_n on any CLK
// SETUP  | address/data presented with CS_n low, one tick before WR_n
// STROBE | WR_n low, counting STROBE_TICKS
// HOLD   | WR_n released, CS_n still low for one tick
// WAIT   | CS_n released, counting the address or data wait time
module opll_write_sequencer
  import opll_seq_pkg::*;
#(
  parameter int DEPTH        = 16,
  parameter int STROBE_TICKS = OPLL_STROBE_TICKS,
  parameter int ADDR_WAIT    = OPLL_ADDR_WAIT,
  parameter int DATA_WAIT    = OPLL_DATA_WAIT
) (
  input  logic                     CLK,
  input  logic                     RESET_n,
  input  logic                     CLK_EN,
  input  logic                     SLOT_RESET_n,
  input  logic                     WR_STB,
  input  logic                     WR_A0,
  input  logic [7:0]               WR_D,
  output logic                     FULL,
  output logic                     EMPTY,
  output logic                     BUSY,
  output logic [$clog2(DEPTH):0]   LEVEL,
  output logic                     OPLL_CS_n,
  output logic                     OPLL_WR_n,
  output logic                     OPLL_A0,
  output logic [7:0]               OPLL_D
`ifdef OPLL_SEQ_DROPCNT_EN
  ,
  output logic [7:0]               DROP_CNT
`endif
);

  localparam int CW = $clog2(max3(STROBE_TICKS, ADDR_WAIT, DATA_WAIT));

  seq_state_t  state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic        cs_n_q, cs_n_d;
  logic        wr_n_q, wr_n_d;
  opll_entry_t ent_q, ent_d;
  opll_entry_t fifo_rdata;
  logic        pop;

  opll_seq_fifo #(
    .DEPTH (DEPTH),
    .WIDTH ($bits(opll_entry_t))
  ) u_fifo (
    .CLK     (CLK),
    .RESET_n (RESET_n),
    .CLR     (!SLOT_RESET_n),
    .PUSH    (WR_STB),
    .POP     (pop),
    .WDATA   ({WR_A0, WR_D}),
    .RDATA   (fifo_rdata),
    .FULL    (FULL),
    .EMPTY   (EMPTY),
    .LEVEL   (LEVEL)
  );

  // Next-state and output decisions; only IDLE ignores CLK_EN.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    cs_n_d  = cs_n_q;
    wr_n_d  = wr_n_q;
    ent_d   = ent_q;
    pop     = 1'b0;
    unique case (state_q)
      IDLE: if (!EMPTY) begin
        pop     = 1'b1;
        ent_d   = fifo_rdata;
        cs_n_d  = 1'b0;
        state_d = SETUP;
      end
      SETUP: if (CLK_EN) begin
        wr_n_d  = 1'b0;
        cnt_d   = CW'(STROBE_TICKS - 1);
        state_d = STROBE;
      end
      STROBE: if (CLK_EN) begin
        if (cnt_q == '0) begin
          wr_n_d  = 1'b1;
          state_d = HOLD;
        end else begin
          cnt_d = cnt_q - CW'(1);
        end
      end
      HOLD: if (CLK_EN) begin
        cs_n_d  = 1'b1;
        cnt_d   = ent_q.a0 ? CW'(DATA_WAIT - 1) : CW'(ADDR_WAIT - 1);
        state_d = WAIT;
      end
      WAIT: if (CLK_EN) begin
        if (cnt_q == '0) state_d = IDLE;
        else             cnt_d   = cnt_q - CW'(1);
      end
      default: state_d = IDLE;
    endcase
  end

  // State and output registers; slot reset abandons any entry in flight.
  always_ff @(posedge CLK or negedge RESET_n) begin
    if (!RESET_n) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      cs_n_q  <= 1'b1;
      wr_n_q  <= 1'b1;
      ent_q   <= '0;
    end else if (!SLOT_RESET_n) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      cs_n_q  <= 1'b1;
      wr_n_q  <= 1'b1;
      ent_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      cs_n_q  <= cs_n_d;
      wr_n_q  <= wr_n_d;
      ent_q   <= ent_d;
    end
  end

  assign BUSY      = (state_q != IDLE);
  assign OPLL_CS_n = cs_n_q;
  assign OPLL_WR_n = wr_n_q;
  assign OPLL_A0   = ent_q.a0;
  assign OPLL_D    = ent_q.d;

`ifdef OPLL_SEQ_DROPCNT_EN
  logic [7:0] drop_q;

  // Saturating count of strobes refused because the FIFO was full.
  always_ff @(posedge CLK or negedge RESET_n) begin
    if (!RESET_n)                                   drop_q <= '0;
    else if (!SLOT_RESET_n)                         drop_q <= '0;
    else if (WR_STB && FULL && !pop && drop_q != 8'hFF) drop_q <= drop_q + 8'd1;
  end

  assign DROP_CNT = drop_q;
`endif

endmodule
